pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage pipeline.
- Decides, each cycle, whether the PC and IF/ID register hold, whether IF/ID and ID/EX are flushed, and whether EX is frozen.
- Sources: load-use hazards (ID vs EX), taken branches resolved in EX, and multi-cycle EX operations (mul/div) with a start/done handshake.
- Sits beside the PC, IF/ID and ID/EX pipeline registers; drives their hold/clear controls.

Parameters:
LU_STALL_CYCLES, 1, bubble cycles inserted per load-use hazard; legal 1..3.
MC_TIMEOUT, 64, max MC_WAIT cycles before forced release; 0 disables timeout; legal 0..65535.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous active-low reset.
id_rs1  in  5  ID-stage source register 1.
id_rs1_used  in  1  ID instruction reads rs1.
id_rs2  in  5  ID-stage source register 2.
id_rs2_used  in  1  ID instruction reads rs2.
ex_rd  in  5  EX-stage destination register.
ex_is_load  in  1  EX instruction is a load.
ex_br_taken  in  1  EX resolved a taken branch/jump.
ex_mc_start  in  1  EX holds a multi-cycle op; single-cycle pulse on entry.
mc_done  in  1  multi-cycle unit result valid (1-cycle pulse).
pc_stall  out  1  hold PC.
if_id_stall  out  1  hold IF/ID register.
if_id_flush  out  1  clear IF/ID to NOP.
id_ex_flush  out  1  clear ID/EX to bubble.
ex_stall  out  1  freeze EX/ID-EX during a multi-cycle op.
ctrl_state  out  2  FSM state: 0 RUN, 1 LU_STALL, 2 MC_WAIT.
mc_err  out  1  sticky: multi-cycle timeout occurred.

Behaviour:
- Outputs are combinational from current state and inputs (Mealy), so stalls act in the same cycle. State, counters and mc_err are registered.
- While rst==0 at a clk edge: state=RUN, counters=0, mc_err=0. With rst low, all stall/flush outputs read 0 and ctrl_state reads 0.
- A reset asserted mid-MC_WAIT or mid-LU_STALL aborts to RUN with no residual stall.
- hazard = ex_is_load & ex_rd!=0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
- RUN, priority ex_br_taken > ex_mc_start > hazard:
  - ex_br_taken: if_id_flush=1, id_ex_flush=1, no stall; stay RUN. A simultaneous hazard or ex_mc_start is ignored.
  - ex_mc_start & mc_done in the same cycle: no stall; stay RUN.
  - ex_mc_start alone: pc_stall=if_id_stall=ex_stall=1; mc counter=1; next MC_WAIT.
  - hazard: pc_stall=if_id_stall=id_ex_flush=1. If LU_STALL_CYCLES>1, load lu counter=LU_STALL_CYCLES-1 and go to LU_STALL; otherwise stay RUN.
  - none of the above: all outputs 0.
- LU_STALL: pc_stall=if_id_stall=id_ex_flush=1; decrement lu counter; when it reaches 1 in this cycle, next state is RUN. ex_br_taken and ex_mc_start are ignored (EX holds a bubble).
- MC_WAIT:
  - mc_done=1: all stall outputs 0 this cycle (release); next RUN.
  - otherwise: pc_stall=if_id_stall=ex_stall=1, id_ex_flush=0; mc counter increments (16-bit, saturating).
  - MC_TIMEOUT!=0 and counter==MC_TIMEOUT with no mc_done: outputs released this cycle, mc_err<=1, next RUN.
  - ex_br_taken is ignored in MC_WAIT.
- if_id_flush and if_id_stall are never both 1. Flush is only asserted in RUN, with no stall.
- mc_err clears only on reset.

Optional Feature:
HAZARD_PERF_EN.
- Defined: adds outputs perf_stall_cnt[31:0] and perf_flush_cnt[31:0], both reset to 0 and wrapping at 2^32.
  - perf_stall_cnt increments every cycle pc_stall=1.
  - perf_flush_cnt increments every cycle if_id_flush=1.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Load-use, LU_STALL_CYCLES=1: ex_is_load=1, ex_rd=5, id_rs1=5, id_rs1_used=1 for 1 cycle -> pc_stall=if_id_stall=id_ex_flush=1 that cycle only; ctrl_state stays 0.
- ex_rd=0 with ex_is_load=1 and id_rs1=0 used -> no stall. id_rs2=7, id_rs2_used=0, ex_rd=7 -> no stall.
- LU_STALL_CYCLES=3, hazard pulse -> stall+bubble for exactly 3 cycles; ctrl_state 0,1,1 then 0.
- Branch with simultaneous hazard and ex_mc_start: ex_br_taken=1 -> if_id_flush=id_ex_flush=1, pc_stall=0, ctrl_state remains 0.
- Multi-cycle: ex_mc_start pulse, mc_done 5 cycles later -> ex_stall=1 for 5 cycles, 0 on the done cycle, RUN next cycle. Also: ex_mc_start & mc_done same cycle -> zero stall.
- Timeout, MC_TIMEOUT=4, mc_done never -> stall for 4 cycles then release; mc_err=1 sticky. Reset (rst=0) mid-MC_WAIT -> next cycle ctrl_state=0, all outputs 0, mc_err=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central stall/flush controller for the 5-stage pipeline.
//
// Optional feature macro: HAZARD_PERF_EN
//   When defined, the outputs perf_stall_cnt and perf_flush_cnt are added.
//   perf_stall_cnt counts cycles with pc_stall=1.
//   perf_flush_cnt counts cycles with if_id_flush=1.
//   Both counters wrap at 2^32.
//
// Hazard sources:
//   - load-use hazards, comparing the ID-stage sources with the EX-stage load
//   - taken branches/jumps resolved in EX
//   - multi-cycle EX operations
//
// Multi-cycle handshake:
//   - ex_mc_start is a one-cycle pulse on the cycle the op enters EX.
//   - mc_done is a one-cycle pulse on the cycle its result is valid.
//   - EX stays frozen from the start pulse until mc_done is seen. Neither
//     side ever waits on the other, so there is no back-pressure.
//   - A start and done in the same cycle need no stall at all.
//   - If MC_TIMEOUT is nonzero, a missing mc_done is cut off after
//     MC_TIMEOUT stall cycles, and the sticky mc_err flag records it.
//
// Outputs are Mealy: they are decoded from the current state and the current
// inputs, so a stall takes effect in the same cycle it is detected.
// ctrl_state exposes the FSM state for debug and checkers.

module pipe_hazard_ctrl #(
  parameter int unsigned LU_STALL_CYCLES = 1,  // bubbles per load-use, 1..3
  parameter int unsigned MC_TIMEOUT      = 64  // 0 disables the timeout
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs1,
  input  logic       id_rs1_used,
  input  logic [4:0] id_rs2,
  input  logic       id_rs2_used,
  input  logic [4:0] ex_rd,
  input  logic       ex_is_load,
  input  logic       ex_br_taken,
  input  logic       ex_mc_start,
  input  logic       mc_done,
  output logic       pc_stall,
  output logic       if_id_stall,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       ex_stall,
  output logic [1:0] ctrl_state,
  output logic       mc_err
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_RUN = 2'd0,
    ST_LU  = 2'd1,
    ST_MC  = 2'd2
  } state_e;

  // Value loaded into the lu counter on hazard detection. The detection
  // cycle is itself the first bubble, so only the remaining ones are counted.
  localparam logic [1:0]  LU_INIT = 2'(LU_STALL_CYCLES - 1);
  localparam logic [15:0] MC_TO   = 16'(MC_TIMEOUT);
  localparam bit          MC_TO_EN = (MC_TIMEOUT != 0);

  state_e      state_q, state_d;
  logic [1:0]  lu_cnt_q, lu_cnt_d;
  logic [15:0] mc_cnt_q, mc_cnt_d;
  logic        mc_err_q, mc_err_d;

  logic        hazard;
  logic        mc_timeout_hit;

  // A load in EX whose destination is read by the instruction in ID.
  // x0 is never a real dependency.
  assign hazard = ex_is_load && (ex_rd != 5'd0) &&
                  ((id_rs1_used && (id_rs1 == ex_rd)) ||
                   (id_rs2_used && (id_rs2 == ex_rd)));

  assign mc_timeout_hit = MC_TO_EN && (mc_cnt_q == MC_TO);

  // State, counters and the sticky error flag. All are cleared by the
  // synchronous reset, so an in-progress stall is dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_RUN;
      lu_cnt_q <= 2'd0;
      mc_cnt_q <= 16'd0;
      mc_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lu_cnt_q <= lu_cnt_d;
      mc_cnt_q <= mc_cnt_d;
      mc_err_q <= mc_err_d;
    end
  end

  // Next-state logic.
  // Priority in RUN: branch > multi-cycle start > load-use.
  always_comb begin
    state_d  = state_q;
    lu_cnt_d = lu_cnt_q;
    mc_cnt_d = mc_cnt_q;
    mc_err_d = mc_err_q;
    case (state_q)
      ST_RUN: begin
        if (ex_br_taken) begin
          // The flush squashes the hazard and the mc op along with the
          // wrong-path instructions.
          state_d = ST_RUN;
        end else if (ex_mc_start) begin
          if (!mc_done) begin
            state_d  = ST_MC;
            mc_cnt_d = 16'd1;
          end
        end else if (hazard) begin
          if (LU_STALL_CYCLES > 1) begin
            state_d  = ST_LU;
            lu_cnt_d = LU_INIT;
          end
        end
      end
      ST_LU: begin
        // EX holds a bubble here, so branch and mc inputs cannot be live.
        lu_cnt_d = lu_cnt_q - 2'd1;
        if (lu_cnt_q <= 2'd1) begin
          state_d = ST_RUN;
        end
      end
      ST_MC: begin
        if (mc_done) begin
          state_d  = ST_RUN;
          mc_cnt_d = 16'd0;
        end else if (mc_timeout_hit) begin
          state_d  = ST_RUN;
          mc_cnt_d = 16'd0;
          mc_err_d = 1'b1;
        end else if (mc_cnt_q != 16'hFFFF) begin
          mc_cnt_d = mc_cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Output decode (Mealy). Everything is held low while reset is asserted.
  // Flush is only ever asserted in RUN without a stall, so if_id_flush and
  // if_id_stall are never both set.
  always_comb begin
    pc_stall    = 1'b0;
    if_id_stall = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ex_stall    = 1'b0;
    if (rst) begin
      case (state_q)
        ST_RUN: begin
          if (ex_br_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (ex_mc_start) begin
            if (!mc_done) begin
              pc_stall    = 1'b1;
              if_id_stall = 1'b1;
              ex_stall    = 1'b1;
            end
          end else if (hazard) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
          end
        end
        ST_LU: begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
        end
        ST_MC: begin
          // Release on done or on timeout. Otherwise the front end and EX
          // are held while the multi-cycle unit works.
          if (!mc_done && !mc_timeout_hit) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            ex_stall    = 1'b1;
          end
        end
        default: begin
          pc_stall = 1'b0;
        end
      endcase
    end
  end

  assign ctrl_state = rst ? state_q : ST_RUN;
  assign mc_err     = mc_err_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_q, perf_flush_q;

  // Performance counters: stall cycles and front-end flush cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_stall_q <= 32'd0;
      perf_flush_q <= 32'd0;
    end else begin
      if (pc_stall) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
      if (if_id_flush) begin
        perf_flush_q <= perf_flush_q + 32'd1;
      end
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl.
//
// Two instances are driven from the same inputs:
//   dut_a: LU_STALL_CYCLES=1, MC_TIMEOUT=64
//   dut_b: LU_STALL_CYCLES=3, MC_TIMEOUT=4
//
// Each observed vector is packed as
//   {pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_stall,
//    ctrl_state[1:0], mc_err}.

module tb_pipe_hazard_ctrl;

  // Clock and reset.
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_rs1_used, id_rs2_used, ex_is_load, ex_br_taken;
  logic       ex_mc_start, mc_done;

  logic       a_pc, a_ifs, a_iff, a_idf, a_exs, a_err;
  logic       b_pc, b_ifs, b_iff, b_idf, b_exs, b_err;
  logic [1:0] a_st, b_st;

`ifdef HAZARD_PERF_EN
  logic [31:0] a_perf_s, a_perf_f, b_perf_s, b_perf_f;
`endif

  pipe_hazard_ctrl #(.LU_STALL_CYCLES(1), .MC_TIMEOUT(64)) dut_a (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
    .id_rs2(id_rs2), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_br_taken(ex_br_taken),
    .ex_mc_start(ex_mc_start), .mc_done(mc_done),
    .pc_stall(a_pc), .if_id_stall(a_ifs), .if_id_flush(a_iff),
    .id_ex_flush(a_idf), .ex_stall(a_exs), .ctrl_state(a_st), .mc_err(a_err)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cnt(a_perf_s), .perf_flush_cnt(a_perf_f)
`endif
  );

  pipe_hazard_ctrl #(.LU_STALL_CYCLES(3), .MC_TIMEOUT(4)) dut_b (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
    .id_rs2(id_rs2), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_br_taken(ex_br_taken),
    .ex_mc_start(ex_mc_start), .mc_done(mc_done),
    .pc_stall(b_pc), .if_id_stall(b_ifs), .if_id_flush(b_iff),
    .id_ex_flush(b_idf), .ex_stall(b_exs), .ctrl_state(b_st), .mc_err(b_err)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cnt(b_perf_s), .perf_flush_cnt(b_perf_f)
`endif
  );

  logic [7:0] obs_a, obs_b;
  assign obs_a = {a_pc, a_ifs, a_iff, a_idf, a_exs, a_st, a_err};
  assign obs_b = {b_pc, b_ifs, b_iff, b_idf, b_exs, b_st, b_err};

  // Control-output patterns: {pc, ifs, iff, idf, exs}.
  localparam logic [4:0] C_N  = 5'b00000;
  localparam logic [4:0] C_LU = 5'b11010;
  localparam logic [4:0] C_BR = 5'b00110;
  localparam logic [4:0] C_MC = 5'b11001;

  // Scoreboard: expected vectors in a,b order per step.
  logic [7:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  function automatic logic [7:0] e(input logic [4:0] ctl, input logic [1:0] st,
                                   input logic err);
    return {ctl, st, err};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Driver tasks.
  // Each step is entered just after a negedge with inputs already set.
  // It pushes the expectations, samples mid-low-phase, compares, and then
  // advances to the next negedge.
  task automatic step(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                      input bit chk_b = 1'b1);
    exp_q.push_back(ea);
    if (chk_b) exp_q.push_back(eb);
    #2;
    check({tag, "_a"}, obs_a, exp_q.pop_front());
    if (chk_b) check({tag, "_b"}, obs_b, exp_q.pop_front());
    @(negedge clk);
  endtask

  task automatic clr();
    id_rs1 = 5'd0; id_rs1_used = 1'b0; id_rs2 = 5'd0; id_rs2_used = 1'b0;
    ex_rd = 5'd0; ex_is_load = 1'b0; ex_br_taken = 1'b0;
    ex_mc_start = 1'b0; mc_done = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] r);
    ex_is_load = 1'b1; ex_rd = r; id_rs1 = r; id_rs1_used = 1'b1;
  endtask

  logic hz;

  initial begin
    clr();
    rst = 1'b0;
    @(negedge clk);
    step("reset_low", e(C_N, 2'd0, 1'b0), e(C_N, 2'd0, 1'b0));
    rst = 1'b1;
    step("idle", e(C_N, 2'd0, 1'b0), e(C_N, 2'd0, 1'b0));

    // Load-use hazard through rs1. dut_b also ignores a branch in LU_STALL.
    set_lu(5'd5);
    step("lu_hit", e(C_LU, 2'd0, 1'b0), e(C_LU, 2'd0, 1'b0));
    clr(); ex_br_taken = 1'b1;
    step("lu_br_ign", e(C_BR, 2'd0, 1'b0), e(C_LU, 2'd1, 1'b0));
    clr();
    step("lu_tail", e(C_N, 2'd0, 1'b0), e(C_LU, 2'd1, 1'b0));
    step("lu_end", e(C_N, 2'd0, 1'b0), e(C_N, 2'd0, 1'b0));

    // x0 destination and unused sources never hazard.
    ex_is_load = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs1_used = 1'b1;
    step("rd_zero", e(C_N, 2'd0, 1'b0), e(C_N, 2'd0, 1'b0));
    ex_rd = 5'd7; id_rs2 = 5'd7; id_rs2_used = 1'b0;
    step("rs2_unused", e(C_N, 2'd0, 1'b0), e(C_N, 2'd0, 1'b0));
    id_rs2_used = 1'b1;
    step("rs2_hit", e(C_LU, 2'd0, 1'b0), e(C_LU, 2'd0, 1'b0));
    clr();
    step("rs2_tail1", e(C_N, 2'd0, 1'b0), e(C_LU, 2'd1, 1'b0));
    step("rs2_tail2", e(C_N, 2'd0, 1'b0), e(C_LU, 2'd1, 1'b0));
    step("rs2_end", e(C_N, 2'd0, 1'b0), e(C_N, 2'd0, 1'b0));

    // A branch beats a simultaneous hazard and multi-cycle start.
    set_lu(5'd5); ex_br_taken = 1'b1; ex_mc_start = 1'b1;
    step("br_prio", e(C_BR, 2'd0, 1'b0), e(C_BR, 2'd0, 1'b0));
    clr();
    step("br_after", e(C_N, 2'd0, 1'b0), e(C_N, 2'd0, 1'b0));

    // Multi-cycle op with mc_done 5 cycles later.
    // dut_b times out after 4 stall cycles.
    ex_mc_start = 1'b1;
    step("mc_start", e(C_MC, 2'd0, 1'b0), e(C_MC, 2'd0, 1'b0));
    clr();
    for (int k = 1; k <= 3; k++) begin
      step("mc_wait", e(C_MC, 2'd2, 1'b0), e(C_MC, 2'd2, 1'b0));
    end
    step("mc_wait4", e(C_MC, 2'd2, 1'b0), e(C_N, 2'd2, 1'b0));
    mc_done = 1'b1;
    step("mc_done", e(C_N, 2'd2, 1'b0), e(C_N, 2'd0, 1'b1));
    clr();
    step("mc_run", e(C_N, 2'd0, 1'b0), e(C_N, 2'd0, 1'b1));
    ex_mc_start = 1'b1; mc_done = 1'b1;
    step("mc_same", e(C_N, 2'd0, 1'b0), e(C_N, 2'd0, 1'b1));
    clr();
    step("mc_same_after", e(C_N, 2'd0, 1'b0), e(C_N, 2'd0, 1'b1));

    // mc_err stays set until a reset edge clears it.
    rst = 1'b0;
    step("rst_err", e(C_N, 2'd0, 1'b0), e(C_N, 2'd0, 1'b1));
    rst = 1'b1;
    step("rst_err_clr", e(C_N, 2'd0, 1'b0), e(C_N, 2'd0, 1'b0));

    // Timeout without mc_done. A branch during MC_WAIT is ignored.
    ex_mc_start = 1'b1;
    step("to_start", e(C_MC, 2'd0, 1'b0), e(C_MC, 2'd0, 1'b0));
    clr();
    step("to_wait1", e(C_MC, 2'd2, 1'b0), e(C_MC, 2'd2, 1'b0));
    ex_br_taken = 1'b1;
    step("mc_br_ign", e(C_MC, 2'd2, 1'b0), e(C_MC, 2'd2, 1'b0));
    clr();
    step("to_wait3", e(C_MC, 2'd2, 1'b0), e(C_MC, 2'd2, 1'b0));
    step("to_release", e(C_MC, 2'd2, 1'b0), e(C_N, 2'd2, 1'b0));
    step("to_err", e(C_MC, 2'd2, 1'b0), e(C_N, 2'd0, 1'b1));
    step("to_sticky", e(C_MC, 2'd2, 1'b0), e(C_N, 2'd0, 1'b1));

    // Reset mid-MC_WAIT on dut_a.
    rst = 1'b0;
    step("rst_mc", e(C_N, 2'd0, 1'b0), e(C_N, 2'd0, 1'b1));
    rst = 1'b1;
    step("rst_mc_after", e(C_N, 2'd0, 1'b0), e(C_N, 2'd0, 1'b0));

    // Reset mid-LU_STALL on dut_b.
    set_lu(5'd9);
    step("lu_pre_rst", e(C_LU, 2'd0, 1'b0), e(C_LU, 2'd0, 1'b0));
    clr();
    rst = 1'b0;
    step("rst_lu", e(C_N, 2'd0, 1'b0), e(C_N, 2'd0, 1'b0));
    rst = 1'b1;
    step("rst_lu_after", e(C_N, 2'd0, 1'b0), e(C_N, 2'd0, 1'b0));

    // Random register patterns on dut_a.
    // dut_b is left unchecked here and reset afterwards.
    for (int i = 0; i < 24; i++) begin
      ex_is_load  = 1'($urandom_range(0, 1));
      ex_rd       = 5'($urandom_range(0, 3));
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      id_rs1_used = 1'($urandom_range(0, 1));
      id_rs2_used = 1'($urandom_range(0, 1));
      hz = ex_is_load && (ex_rd != 5'd0) &&
           ((id_rs1_used && (id_rs1 == ex_rd)) || (id_rs2_used && (id_rs2 == ex_rd)));
      step("rand_lu", e(hz ? C_LU : C_N, 2'd0, 1'b0), 8'd0, 1'b0);
    end
    clr();
    rst = 1'b0;
    step("rst_final", e(C_N, 2'd0, 1'b0), e(C_N, 2'd0, 1'b0));
    rst = 1'b1;
    step("final_idle", e(C_N, 2'd0, 1'b0), e(C_N, 2'd0, 1'b0));

    // Final report.
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
